// File: rtl/peripheral_spram_arbiter_if.sv
// Requester-side bus of the SPRAM arbiter: request/grant handshake plus a
// one-cycle-delayed response channel.
interface peripheral_spram_arbiter_if #(
  parameter int unsigned AW = 6,
  parameter int unsigned DW = 16
);
  logic          req;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
  logic [1:0]    wen;
  logic          gnt;
  logic          rvalid;
  logic          err;
  logic [DW-1:0] rdata;

  modport master (output req, addr, din, wen, input gnt, rvalid, err, rdata);
  modport slave  (input req, addr, din, wen, output gnt, rvalid, err, rdata);
endinterface

// File: rtl/peripheral_spram_arbiter.sv
// Round-robin two-port arbiter in front of a single-port SPRAM macro; one
// access per cycle, out-of-range words answered with an error and no RAM cycle.
module peripheral_spram_arbiter #(
  parameter int unsigned AW       = 6,
  parameter int unsigned DW       = 16,
  parameter int unsigned MEM_SIZE = 256
) (
  input  logic                         ram_clk,
  input  logic                         ram_rst_n,
  peripheral_spram_arbiter_if.slave    a,
  peripheral_spram_arbiter_if.slave    b,
  output logic [AW-1:0]                ram_addr,
  output logic [DW-1:0]                ram_din,
  output logic                         ram_cen,
  output logic [1:0]                   ram_wen,
  input  logic [DW-1:0]                ram_dout
);

  localparam int unsigned VALID_WORDS = MEM_SIZE / (DW / 8);

  typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_e;

  port_e         last, last_nxt;
  logic          pend_a, pend_b, pend_rd, pend_err;
  logic          pend_a_nxt, pend_b_nxt, pend_rd_nxt, pend_err_nxt;
  logic          grant_a, grant_b, oor;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_din;
  logic [1:0]    win_wen;

  // Pointer and response tags; reset drops any response still in flight.
  always_ff @(posedge ram_clk or negedge ram_rst_n) begin
    if (!ram_rst_n) begin
      last     <= PORT_B;
      pend_a   <= 1'b0;
      pend_b   <= 1'b0;
      pend_rd  <= 1'b0;
      pend_err <= 1'b0;
    end else begin
      last     <= last_nxt;
      pend_a   <= pend_a_nxt;
      pend_b   <= pend_b_nxt;
      pend_rd  <= pend_rd_nxt;
      pend_err <= pend_err_nxt;
    end
  end

  // Arbitration: sole requester wins, on contention the port not served last.
  always_comb begin
    grant_a  = 1'b0;
    grant_b  = 1'b0;
    last_nxt = last;
    if (ram_rst_n) begin
      if (a.req && (!b.req || last == PORT_B)) grant_a = 1'b1;
      else if (b.req)                          grant_b = 1'b1;
    end
    if (grant_a)      last_nxt = PORT_A;
    else if (grant_b) last_nxt = PORT_B;
  end

  assign win_addr = grant_b ? b.addr : a.addr;
  assign win_din  = grant_b ? b.din  : a.din;
  assign win_wen  = grant_b ? b.wen  : a.wen;

  // When the address space fits inside the RAM no word can be out of range.
  generate
    if ((64'(1) << AW) <= 64'(VALID_WORDS)) begin : g_no_range
      assign oor = 1'b0;
    end else begin : g_range
      assign oor = (win_addr >= AW'(VALID_WORDS));
    end
  endgenerate

  // RAM port drive and response tags for next cycle.
  always_comb begin
    ram_cen      = 1'b1;
    ram_wen      = 2'b11;
    ram_addr     = a.addr;
    ram_din      = a.din;
    pend_a_nxt   = grant_a;
    pend_b_nxt   = grant_b;
    pend_rd_nxt  = (win_wen == 2'b11);
    pend_err_nxt = (grant_a || grant_b) && oor;
    if ((grant_a || grant_b) && !oor) begin
      ram_cen  = 1'b0;
      ram_wen  = win_wen;
      ram_addr = win_addr;
      ram_din  = win_din;
    end
  end

  assign a.gnt    = grant_a;
  assign b.gnt    = grant_b;
  assign a.rvalid = pend_a;
  assign b.rvalid = pend_b;
  assign a.err    = pend_a && pend_err;
  assign b.err    = pend_b && pend_err;
  assign a.rdata  = (pend_a && pend_rd && !pend_err) ? ram_dout : '0;
  assign b.rdata  = (pend_b && pend_rd && !pend_err) ? ram_dout : '0;

endmodule

// File: tb/tb_peripheral_spram_arbiter.sv
// Directed bench for peripheral_spram_arbiter with a behavioural SPRAM model.
module tb_peripheral_spram_arbiter;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 16;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_cen;
  logic [1:0]    ram_wen;
  logic [DW-1:0] ram_dout;
  logic [DW-1:0] mem [256];

  int checks = 0;
  int errors = 0;

  peripheral_spram_arbiter_if #(.AW(AW), .DW(DW)) ia ();
  peripheral_spram_arbiter_if #(.AW(AW), .DW(DW)) ib ();

  peripheral_spram_arbiter #(.AW(AW), .DW(DW), .MEM_SIZE(256)) dut (
    .ram_clk   (clk),
    .ram_rst_n (rst_n),
    .a         (ia),
    .b         (ib),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_cen   (ram_cen),
    .ram_wen   (ram_wen),
    .ram_dout  (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SPRAM: byte-masked write, registered read, one-cycle latency.
  always @(posedge clk) begin
    if (!ram_cen) begin
      if (!ram_wen[0]) mem[ram_addr][7:0]  <= ram_din[7:0];
      if (!ram_wen[1]) mem[ram_addr][15:8] <= ram_din[15:8];
      ram_dout <= mem[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply both ports' inputs just after the falling edge, settle 1ns.
  task automatic drive(input logic ar, input logic [7:0] aa, input logic [15:0] ad,
                       input logic [1:0] aw, input logic br, input logic [7:0] ba,
                       input logic [15:0] bd, input logic [1:0] bw);
    @(negedge clk);
    ia.req = ar; ia.addr = aa; ia.din = ad; ia.wen = aw;
    ib.req = br; ib.addr = ba; ib.din = bd; ib.wen = bw;
    #1;
  endtask

  task automatic to_resp();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " a_gnt"}, 32'(ia.gnt), 32'd0);
    chk({tag, " b_gnt"}, 32'(ib.gnt), 32'd0);
    chk({tag, " a_rvalid"}, 32'(ia.rvalid), 32'd0);
    chk({tag, " b_rvalid"}, 32'(ib.rvalid), 32'd0);
    chk({tag, " a_err"}, 32'(ia.err), 32'd0);
    chk({tag, " b_err"}, 32'(ib.err), 32'd0);
    chk({tag, " a_rdata"}, 32'(ia.rdata), 32'd0);
    chk({tag, " b_rdata"}, 32'(ib.rdata), 32'd0);
    chk({tag, " ram_cen"}, 32'(ram_cen), 32'd1);
    chk({tag, " ram_wen"}, 32'(ram_wen), 32'd3);
  endtask

  initial begin
    logic [15:0] rd_exp [3];
    rst_n = 1'b0;
    ia.req = 1'b1; ia.addr = 8'd5; ia.din = 16'h0; ia.wen = 2'b11;
    ib.req = 1'b1; ib.addr = 8'd6; ib.din = 16'h0; ib.wen = 2'b11;
    #12;
    chk_reset_outputs("reset");

    // Release with ports idle, then a full-word write to addr 5.
    drive(1'b0, 8'd0, 16'h0, 2'b11, 1'b0, 8'd0, 16'h0, 2'b11);
    rst_n = 1'b1;
    drive(1'b1, 8'd5, 16'hBEEF, 2'b00, 1'b0, 8'd0, 16'h0, 2'b11);
    chk("t1 a_gnt", 32'(ia.gnt), 32'd1);
    chk("t1 ram_cen", 32'(ram_cen), 32'd0);
    chk("t1 ram_wen", 32'(ram_wen), 32'd0);
    chk("t1 ram_addr", 32'(ram_addr), 32'd5);
    to_resp();
    chk("t1 a_rvalid", 32'(ia.rvalid), 32'd1);
    chk("t1 a_err", 32'(ia.err), 32'd0);
    chk("t1 a_rdata", 32'(ia.rdata), 32'd0);
    chk("t1 b_rvalid", 32'(ib.rvalid), 32'd0);
    drive(1'b1, 8'd5, 16'h0, 2'b11, 1'b0, 8'd0, 16'h0, 2'b11);
    to_resp();
    chk("t1 readback", 32'(ia.rdata), 32'hBEEF);

    // Low-byte-only write merges into the stored word.
    drive(1'b1, 8'd5, 16'h1234, 2'b10, 1'b0, 8'd0, 16'h0, 2'b11);
    to_resp();
    drive(1'b1, 8'd5, 16'h0, 2'b11, 1'b0, 8'd0, 16'h0, 2'b11);
    to_resp();
    chk("t3 byte merge", 32'(ia.rdata), 32'hBE34);

    // Preload addr 1 via A and addr 2 via B (leaves pointer on B).
    drive(1'b1, 8'd1, 16'h1111, 2'b00, 1'b0, 8'd0, 16'h0, 2'b11);
    drive(1'b0, 8'd0, 16'h0, 2'b11, 1'b1, 8'd2, 16'h2222, 2'b00);
    chk("t2 b preload gnt", 32'(ib.gnt), 32'd1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'd1, 16'h0, 2'b11, 1'b1, 8'd2, 16'h0, 2'b11);
      chk($sformatf("t2 a_gnt[%0d]", i), 32'(ia.gnt), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("t2 b_gnt[%0d]", i), 32'(ib.gnt), (i % 2 == 0) ? 32'd0 : 32'd1);
      to_resp();
      chk($sformatf("t2 a_rvalid[%0d]", i), 32'(ia.rvalid), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("t2 b_rvalid[%0d]", i), 32'(ib.rvalid), (i % 2 == 0) ? 32'd0 : 32'd1);
      chk($sformatf("t2 a_rdata[%0d]", i), 32'(ia.rdata), (i % 2 == 0) ? 32'h1111 : 32'h0);
      chk($sformatf("t2 b_rdata[%0d]", i), 32'(ib.rdata), (i % 2 == 0) ? 32'h0 : 32'h2222);
    end

    // First out-of-range word: granted, RAM untouched, error response.
    drive(1'b0, 8'd0, 16'h0, 2'b11, 1'b1, 8'h80, 16'h0, 2'b11);
    chk("t4 b_gnt oor", 32'(ib.gnt), 32'd1);
    chk("t4 ram_cen oor", 32'(ram_cen), 32'd1);
    chk("t4 ram_wen oor", 32'(ram_wen), 32'd3);
    to_resp();
    chk("t4 b_rvalid oor", 32'(ib.rvalid), 32'd1);
    chk("t4 b_err oor", 32'(ib.err), 32'd1);
    chk("t4 b_rdata oor", 32'(ib.rdata), 32'd0);
    drive(1'b0, 8'd0, 16'h0, 2'b11, 1'b1, 8'h7F, 16'h7E7F, 2'b00);
    chk("t4 ram_cen last word", 32'(ram_cen), 32'd0);
    drive(1'b0, 8'd0, 16'h0, 2'b11, 1'b1, 8'h7F, 16'h0, 2'b11);
    to_resp();
    chk("t4 b_err last word", 32'(ib.err), 32'd0);
    chk("t4 b_rdata last word", 32'(ib.rdata), 32'h7E7F);

    // B alone: three back-to-back writes, then three back-to-back reads.
    rd_exp[0] = 16'hA00A; rd_exp[1] = 16'hB00B; rd_exp[2] = 16'hC00C;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'd0, 16'h0, 2'b11, 1'b1, 8'(10 + i), rd_exp[i], 2'b00);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'd0, 16'h0, 2'b11, 1'b1, 8'(10 + i), 16'h0, 2'b11);
      chk($sformatf("t6 b_gnt[%0d]", i), 32'(ib.gnt), 32'd1);
      to_resp();
      chk($sformatf("t6 b_rvalid[%0d]", i), 32'(ib.rvalid), 32'd1);
      chk($sformatf("t6 b_rdata[%0d]", i), 32'(ib.rdata), 32'(rd_exp[i]));
    end

    // A read is granted, reset hits at the next edge: its response is dropped.
    drive(1'b1, 8'd5, 16'h0, 2'b11, 1'b0, 8'd0, 16'h0, 2'b11);
    chk("t5 a_gnt pre", 32'(ia.gnt), 32'd1);
    @(posedge clk);
    rst_n = 1'b0;
    ib.req = 1'b1;
    #1;
    chk_reset_outputs("t5 in reset");
    @(negedge clk);
    #1;
    chk_reset_outputs("t5 in reset late");
    drive(1'b1, 8'd1, 16'h0, 2'b11, 1'b1, 8'd2, 16'h0, 2'b11);
    rst_n = 1'b1;
    #1;
    chk("t5 a_gnt after reset", 32'(ia.gnt), 32'd1);
    chk("t5 b_gnt after reset", 32'(ib.gnt), 32'd0);
    to_resp();
    chk("t5 a_rdata after reset", 32'(ia.rdata), 32'h1111);

    drive(1'b0, 8'd0, 16'h0, 2'b11, 1'b0, 8'd0, 16'h0, 2'b11);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/peripheral_spram_arbiter.md
# peripheral_spram_arbiter

Two-requester arbiter and sequencer for the single-port SPRAM macro (`peripheral_spram_bb`). It grants at most one access per cycle, round-robin between port A (CPU) and port B (DMA). It drives the RAM's low-active chip and write enables and routes the 1-cycle-latency read data back to the winning requester. It also rejects out-of-range word addresses with an error response, without touching the RAM.

## Interface
- `AW`, 6, RAM word-address width (shared by requester ports and RAM port)
- `DW`, 16, data width; byte lanes = DW/8, fixed at 2
- `MEM_SIZE`, 256, memory size in bytes; valid words = MEM_SIZE/(DW/8)

- `ram_clk` in 1: single clock for arbiter and RAM
- `ram_rst_n` in 1: reset, asynchronous and active-low
- `a_req`, `b_req` in 1: access request, held until granted
- `a_addr`, `b_addr` in AW: word address
- `a_din`, `b_din` in DW: write data
- `a_wen`, `b_wen` in 2: byte write enables, low active; 2'b11 = read
- `a_gnt`, `b_gnt` out 1: access accepted this cycle (combinational)
- `a_rvalid`, `b_rvalid` out 1: response for the access granted in the previous cycle
- `a_err`, `b_err` out 1: qualifies rvalid; address was out of range
- `a_rdata`, `b_rdata` out DW: read data, qualified by rvalid
- `ram_addr` out AW, `ram_din` out DW: to RAM
- `ram_cen` out 1: RAM chip enable, low active
- `ram_wen` out 2: RAM byte write enable, low active
- `ram_dout` in DW: RAM read data, valid one cycle after a cen=0 read

## Operation
- State: 1-bit `last` pointer (last granted port), plus registered response tags.
- Response tags: `pend_a`, `pend_b`, `pend_rd`, `pend_err`.
- Arbitration (combinational, each cycle):
  - If only one port requests, that port wins.
  - If both request, the port not equal to `last` wins.
  - `last` updates to the winner at the clock edge.
- Range check: winning address >= MEM_SIZE/(DW/8) → out of range.
  - Grant is still given.
  - `ram_cen` stays 1.
  - Response has err=1.
- Normal grant:
  - `ram_cen`=0.
  - `ram_addr`, `ram_din`, `ram_wen` muxed from the winner.
- No grant:
  - `ram_cen`=1, `ram_wen`=2'b11.
  - `ram_addr` and `ram_din` hold the port A values; the RAM does not sample them.
- Response (next cycle after any grant):
  - Winner's `rvalid`=1.
  - `err`=pend_err.
  - `rdata`=`ram_dout` if (read and not err), else 0.
  - Writes receive an ack-only response (rdata=0).
- Non-winning port: gnt=0; its request is held and competes again next cycle.
- Back-to-back grants are allowed every cycle. A response and a new grant may occur in the same cycle.

## Timing
- Reset values (asynchronous, while `ram_rst_n`=0):
  - `last`=B, so A wins the first contention.
  - All pend tags 0.
  - rvalid/err/rdata = 0 for both ports.
  - gnt forced 0 for both ports.
  - `ram_cen`=1, `ram_wen`=2'b11.
- Latency: req to gnt 0 cycles; gnt to rvalid exactly 1 cycle; sustained throughput 1 access/cycle.
- Requesters must keep addr/din/wen stable while req=1 and gnt=0.
- Reset asserted mid-access: the pending response is discarded (rvalid never pulses). An in-flight RAM write issued at the preceding edge is not rolled back.
- Reset deassertion: the first grant can occur in the first cycle with `ram_rst_n`=1.
- Boundary address: the last valid word is MEM_SIZE/(DW/8)-1 and is accepted; the next word returns err. When 2^AW <= valid words, err is never asserted.

## Test plan
1. After reset, a_req=1, a_addr=5, a_wen=2'b00, a_din=16'hBEEF → same-cycle a_gnt=1, ram_cen=0, ram_wen=2'b00. Next cycle: a_rvalid=1, a_err=0, a_rdata=0. A later read of addr 5 returns a_rdata=16'hBEEF.
2. Both ports hold read requests to addresses 1 and 2 for 4 cycles → grants alternate A,B,A,B. Each rvalid follows its grant by 1 cycle with the correct data.
3. Byte write a_wen=2'b10, a_din=16'h1234 to a word holding 16'hBEEF → readback 16'hBE34.
4. With AW=8, MEM_SIZE=256, b_req=1, b_addr=8'h80 → b_gnt=1 with ram_cen=1. Next cycle: b_rvalid=1, b_err=1, b_rdata=0. Address 8'h7F returns err=0.
5. ram_rst_n pulsed low for 1 cycle right after a granted read → no rvalid is seen, all outputs are at reset values during reset, and A wins the first contention afterwards.
6. b_req held alone for 3 cycles to addresses 10,11,12 → 3 consecutive grants and 3 consecutive rvalids returning the stored words in order.
